// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add MULTU and restoring DIVU, one bit per clock.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             control_error,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SLL   = 4'b1101;
    localparam logic [3:0] OP_SRL   = 4'b1110;
    localparam logic [3:0] OP_SRA   = 4'b1111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, op_b;
    logic [WIDTH-1:0] alu_out;
    logic             legal;

    always_comb begin
        alu_out = '0;
        legal   = 1'b1;
        case (alu_control)
            OP_AND:   alu_out = data1 & data2;
            OP_OR:    alu_out = data1 | data2;
            OP_ADD:   alu_out = data1 + data2;
            OP_SUB:   alu_out = data1 - data2;
            OP_SLT:   alu_out = {{(WIDTH-1){1'b0}}, (data1 < data2)};
            OP_NOR:   alu_out = ~(data1 | data2);
            OP_SLL:   alu_out = data2 << shamt;
            OP_SRL:   alu_out = data2 >> shamt;
            OP_SRA:   alu_out = $signed(data2) >>> shamt;
            OP_MULTU: alu_out = '0;
            OP_DIVU:  alu_out = '0;
            default:  legal   = 1'b0;
        endcase
    end

    // Multiply step: acc_lo holds the unconsumed multiplier bits, product shifts in from the top.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring divide step: acc_hi is the partial remainder, acc_lo dividend/quotient.
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, op_b};
    assign div_ge   = div_sh >= {1'b0, op_b};
    assign div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lo_n = {acc_lo[WIDTH-2:0], div_ge};

    logic last;
    assign last = (cnt == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            op_b          <= '0;
            result        <= '0;
            result_hi     <= '0;
            control_error <= 1'b0;
            div_zero      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cnt           <= '0;
                    div_zero      <= 1'b0;
                    control_error <= 1'b0;
                    acc_hi        <= '0;
                    acc_lo        <= data1;
                    op_b          <= data2;
                    if (alu_control == OP_MULTU) begin
                        state <= S_MUL;
                    end else if (alu_control == OP_DIVU) begin
                        if (data2 == '0) begin
                            result    <= '1;
                            result_hi <= data1;
                            div_zero  <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_DIV;
                        end
                    end else begin
                        if (legal) begin
                            result    <= alu_out;
                            result_hi <= '0;
                        end else begin
                            control_error <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        result    <= mul_lo_n;
                        result_hi <= mul_hi_n;
                        state     <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc_hi <= div_hi_n;
                    acc_lo <= div_lo_n;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        result    <= div_lo_n;
                        result_hi <= div_hi_n;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    // Illegal-op flag is a one-cycle indication; div_zero persists.
                    control_error <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_MUL) || (state == S_DIV);
    assign done = (state == S_DONE);
    assign zero = (result == '0);
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized self-checking bench for alu_multicycle (WIDTH=32) against an
// arithmetic reference model; also covers directed corner cases and reset abort.
module tb_alu_multicycle;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    alu_control;
    logic [W-1:0]  data1, data2;
    logic [4:0]    shamt;
    logic [W-1:0]  result, result_hi;
    logic          busy, done, zero, control_error, div_zero;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_lo, exp_hi;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
        .data1(data1), .data2(data2), .shamt(shamt),
        .result(result), .result_hi(result_hi), .busy(busy), .done(done),
        .zero(zero), .control_error(control_error), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    // Issue one op at posedge+1, follow it to completion, check flags and results.
    task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh, input bit inject);
        logic [63:0] prod;
        bit ok, dz, multi;
        int lat;
        ok = 1; dz = 0; multi = 0;
        case (ctl)
            4'b0000: exp_lo = a & b;
            4'b0001: exp_lo = a | b;
            4'b0010: exp_lo = a + b;
            4'b0110: exp_lo = a - b;
            4'b0111: exp_lo = (a < b) ? 1 : 0;
            4'b1100: exp_lo = ~(a | b);
            4'b1101: exp_lo = b << sh;
            4'b1110: exp_lo = b >> sh;
            4'b1111: exp_lo = W'($signed(b) >>> sh);
            4'b1000: begin prod = 64'(a) * 64'(b); exp_lo = prod[31:0]; exp_hi = prod[63:32]; multi = 1; end
            4'b1001: if (b == 0) begin exp_lo = '1; exp_hi = a; dz = 1; end
                     else begin exp_lo = a / b; exp_hi = a % b; multi = 1; end
            default: ok = 0;
        endcase
        if (ok && ctl != 4'b1000 && ctl != 4'b1001) exp_hi = '0;
        lat = multi ? W + 1 : 1;

        alu_control = ctl; data1 = a; data2 = b; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        data1 = $urandom; data2 = $urandom; shamt = 5'($urandom); alu_control = 4'($urandom);
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin @(posedge clk); #1; start = 1'b0; end
            chk("busy_done", {62'd0, busy, done}, {62'd0, c < lat, c == lat});
            if (inject && (c == 3 || c == lat)) begin
                alu_control = 4'($urandom); data1 = $urandom; data2 = $urandom; start = 1'b1;
            end
        end
        chk("result", 64'(result), 64'(exp_lo));
        chk("result_hi", 64'(result_hi), 64'(exp_hi));
        chk("flags", {61'd0, zero, div_zero, control_error}, {61'd0, exp_lo == 0, dz, !ok});
        @(posedge clk); #1; start = 1'b0;
        chk("after_done", {61'd0, busy, done, control_error}, 64'd0);
        chk("hold", {result_hi, result}, {exp_hi, exp_lo});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_control = '0; data1 = '0; data2 = '0; shamt = '0;
        exp_lo = '0; exp_hi = '0;
        #12;
        chk("reset", {result_hi, result}, 64'd0);
        chk("reset_flags", {59'd0, busy, done, control_error, div_zero, zero}, 64'd1);
        @(posedge clk); #1; rst_n = 1'b1;

        run_op(4'b0010, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
        run_op(4'b0110, 32'd5, 32'd7, 5'd0, 0);
        run_op(4'b1111, 32'd0, 32'h80000000, 5'd4, 0);
        run_op(4'b1110, 32'd0, 32'h80000000, 5'd4, 0);
        run_op(4'b0111, 32'd3, 32'hFFFFFFFF, 5'd0, 0);
        run_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1);
        run_op(4'b1001, 32'd100, 32'd7, 5'd0, 1);
        run_op(4'b1001, 32'd9, 32'd0, 5'd0, 0);
        run_op(4'b0011, 32'd1, 32'd2, 5'd0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(4'($urandom_range(0, 15)), a, b, 5'($urandom), 1'($urandom));
        end

        // Reset during a multiply aborts it without a done pulse.
        alu_control = 4'b1000; data1 = 32'h12345678; data2 = 32'h9ABCDEF0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
        chk("mid_mul_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0; #1;
        chk("abort_data", {result_hi, result}, 64'd0);
        chk("abort_flags", {59'd0, busy, done, control_error, div_zero, zero}, 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end
        rst_n = 1'b1; exp_lo = '0; exp_hi = '0;
        run_op(4'b0010, 32'd40, 32'd2, 5'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
